// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory.
// It accepts one access per cycle, checks the address and returns a registered response to the winning port.
module dmem_arbiter #(
    parameter int DEPTH    = 64,
    parameter int AW       = 6,
    parameter bit CPU_PRIO = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_valid,
    input  logic          p0_we,
    input  logic [31:0]   p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_ready,
    output logic          p0_rsp_valid,
    output logic [31:0]   p0_rsp_rdata,
    output logic          p0_rsp_err,
    input  logic          p1_valid,
    input  logic          p1_we,
    input  logic [31:0]   p1_addr,
    input  logic [31:0]   p1_wdata,
    output logic          p1_ready,
    output logic          p1_rsp_valid,
    output logic [31:0]   p1_rsp_rdata,
    output logic          p1_rsp_err,
    output logic          mem_we,
    output logic          mem_re,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy
);

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    logic          pointer;   // 0 favours port 0 on a contested cycle
    logic          gnt0;
    logic          gnt1;
    logic          contested;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic          sel_we;
    logic          sel_err;
    logic [AW-1:0] sel_idx;

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        contested = 1'b0;
        if (!reset) begin
            if (p0_valid && p1_valid) begin
                contested = 1'b1;
                if (CPU_PRIO || !pointer) gnt0 = 1'b1;
                else                      gnt1 = 1'b1;
            end else begin
                gnt0 = p0_valid;
                gnt1 = p1_valid;
            end
        end

        sel_addr  = gnt1 ? p1_addr  : p0_addr;
        sel_wdata = gnt1 ? p1_wdata : p0_wdata;
        sel_we    = gnt1 ? p1_we    : p0_we;
        sel_err   = (sel_addr[1:0] != 2'b00) || ({2'b00, sel_addr[31:2]} >= DEPTH_W);
        sel_idx   = sel_addr[AW+1:2];

        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if ((gnt0 || gnt1) && !sel_err) begin
            mem_addr = sel_idx;
            if (sel_we) begin
                mem_we    = 1'b1;
                mem_wdata = sel_wdata;
            end else begin
                mem_re = 1'b1;
            end
        end
    end

    assign p0_ready = gnt0;
    assign p1_ready = gnt1;
    assign busy     = gnt0 | gnt1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pointer      <= 1'b0;
            p0_rsp_valid <= 1'b0;
            p0_rsp_rdata <= '0;
            p0_rsp_err   <= 1'b0;
            p1_rsp_valid <= 1'b0;
            p1_rsp_rdata <= '0;
            p1_rsp_err   <= 1'b0;
        end else begin
            p0_rsp_valid <= gnt0;
            p1_rsp_valid <= gnt1;
            // rdata/err hold between responses; only the winner's are updated
            if (gnt0) begin
                p0_rsp_err   <= sel_err;
                p0_rsp_rdata <= (!sel_err && !sel_we) ? mem_rdata : '0;
            end
            if (gnt1) begin
                p1_rsp_err   <= sel_err;
                p1_rsp_rdata <= (!sel_err && !sel_we) ? mem_rdata : '0;
            end
            if (contested) pointer <= gnt0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a round-robin instance with a full response scoreboard,
// plus a CPU-priority instance for the fixed-priority case.
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic init_done = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // round-robin instance
    logic        r0_valid = 0, r0_we = 0, r1_valid = 0, r1_we = 0;
    logic [31:0] r0_addr = 0, r0_wdata = 0, r1_addr = 0, r1_wdata = 0;
    logic        r0_ready, r0_rsp_valid, r0_rsp_err, r1_ready, r1_rsp_valid, r1_rsp_err;
    logic [31:0] r0_rsp_rdata, r1_rsp_rdata;
    logic        r_mem_we, r_mem_re, r_busy;
    logic [5:0]  r_mem_addr;
    logic [31:0] r_mem_wdata, r_mem_rdata;
    logic [31:0] rmem [64];

    // CPU-priority instance
    logic        q0_valid = 0, q1_valid = 0;
    logic [31:0] q0_addr = 0, q1_addr = 0;
    logic        q0_ready, q0_rsp_valid, q0_rsp_err, q1_ready, q1_rsp_valid, q1_rsp_err;
    logic [31:0] q0_rsp_rdata, q1_rsp_rdata;
    logic        q_mem_we, q_mem_re, q_busy;
    logic [5:0]  q_mem_addr;
    logic [31:0] q_mem_wdata, q_mem_rdata;
    logic [31:0] qmem [64];

    logic [31:0] shadow [64];

    typedef struct {
        int          port;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t sbq[$];

    dmem_arbiter #(.DEPTH(64), .AW(6), .CPU_PRIO(1'b0)) u_rr (
        .clk(clk), .reset(reset),
        .p0_valid(r0_valid), .p0_we(r0_we), .p0_addr(r0_addr), .p0_wdata(r0_wdata),
        .p0_ready(r0_ready), .p0_rsp_valid(r0_rsp_valid), .p0_rsp_rdata(r0_rsp_rdata), .p0_rsp_err(r0_rsp_err),
        .p1_valid(r1_valid), .p1_we(r1_we), .p1_addr(r1_addr), .p1_wdata(r1_wdata),
        .p1_ready(r1_ready), .p1_rsp_valid(r1_rsp_valid), .p1_rsp_rdata(r1_rsp_rdata), .p1_rsp_err(r1_rsp_err),
        .mem_we(r_mem_we), .mem_re(r_mem_re), .mem_addr(r_mem_addr), .mem_wdata(r_mem_wdata),
        .mem_rdata(r_mem_rdata), .busy(r_busy)
    );

    dmem_arbiter #(.DEPTH(64), .AW(6), .CPU_PRIO(1'b1)) u_pr (
        .clk(clk), .reset(reset),
        .p0_valid(q0_valid), .p0_we(1'b0), .p0_addr(q0_addr), .p0_wdata(32'h0),
        .p0_ready(q0_ready), .p0_rsp_valid(q0_rsp_valid), .p0_rsp_rdata(q0_rsp_rdata), .p0_rsp_err(q0_rsp_err),
        .p1_valid(q1_valid), .p1_we(1'b0), .p1_addr(q1_addr), .p1_wdata(32'h0),
        .p1_ready(q1_ready), .p1_rsp_valid(q1_rsp_valid), .p1_rsp_rdata(q1_rsp_rdata), .p1_rsp_err(q1_rsp_err),
        .mem_we(q_mem_we), .mem_re(q_mem_re), .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata),
        .mem_rdata(q_mem_rdata), .busy(q_busy)
    );

    // data memory models: combinational read, write at the clock edge
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 64; i++) begin
                rmem[i] <= 32'hA500_0000 | 32'(i);
                qmem[i] <= 32'hA500_0000 | 32'(i);
            end
        end else begin
            if (r_mem_we) rmem[r_mem_addr] <= r_mem_wdata;
            if (q_mem_we) qmem[q_mem_addr] <= q_mem_wdata;
        end
    end
    assign r_mem_rdata = rmem[r_mem_addr];
    assign q_mem_rdata = qmem[q_mem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic exp_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'h0000_0100);
    endfunction

    // one cycle on the round-robin instance; gnt: 0 none, 1 port 0, 2 port 1
    task automatic step(input logic v0, input logic we0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic v1, input logic we1, input logic [31:0] a1, input logic [31:0] d1,
                        input int gnt);
        logic [31:0] a, d;
        logic        we, e;
        logic [5:0]  idx;
        exp_t        x;
        @(posedge clk);
        #1;
        r0_valid = v0; r0_we = we0; r0_addr = a0; r0_wdata = d0;
        r1_valid = v1; r1_we = we1; r1_addr = a1; r1_wdata = d1;
        @(negedge clk);
        check("p0_ready", r0_ready, gnt == 1);
        check("p1_ready", r1_ready, gnt == 2);
        check("busy", r_busy, gnt != 0);
        if (gnt != 0) begin
            a   = (gnt == 2) ? a1 : a0;
            d   = (gnt == 2) ? d1 : d0;
            we  = (gnt == 2) ? we1 : we0;
            e   = exp_err(a);
            idx = a[7:2];
            check("mem_we", r_mem_we, !e && we);
            check("mem_re", r_mem_re, !e && !we);
            if (!e) check("mem_addr", r_mem_addr, idx);
            if (!e && we) check("mem_wdata", r_mem_wdata, d);
            x.port  = gnt - 1;
            x.err   = e;
            x.rdata = (!e && !we) ? shadow[idx] : 32'h0;
            x.cyc   = cyc + 1;
            sbq.push_back(x);
            if (!e && we) shadow[idx] = d;
        end else begin
            check("idle_mem_we", r_mem_we, 0);
            check("idle_mem_re", r_mem_re, 0);
            check("idle_mem_addr", r_mem_addr, 0);
            check("idle_mem_wdata", r_mem_wdata, 0);
        end
    endtask

    // response monitor for the round-robin instance
    always @(negedge clk) begin
        exp_t x;
        if (!reset && init_done) begin
            if (r0_rsp_valid && r1_rsp_valid) begin
                check("rsp_both_ports", {r0_rsp_valid, r1_rsp_valid}, 0);
            end else if (r0_rsp_valid || r1_rsp_valid) begin
                if (sbq.size() == 0) begin
                    check("rsp_unexpected", {r0_rsp_valid, r1_rsp_valid}, 0);
                end else begin
                    x = sbq.pop_front();
                    check("rsp_port", r1_rsp_valid ? 1 : 0, x.port);
                    check("rsp_latency", cyc, x.cyc);
                    check("rsp_err", r1_rsp_valid ? r1_rsp_err : r0_rsp_err, x.err);
                    check("rsp_rdata", r1_rsp_valid ? r1_rsp_rdata : r0_rsp_rdata, x.rdata);
                end
            end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
                check("rsp_missing", r0_rsp_valid | r1_rsp_valid, 1);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) shadow[i] = 32'hA500_0000 | 32'(i);
        r0_valid = 1; r0_addr = 32'h10;
        repeat (3) @(negedge clk);
        check("rst_p0_ready", r0_ready, 0);
        check("rst_mem_re", r_mem_re, 0);
        check("rst_busy", r_busy, 0);
        check("rst_p0_rsp_valid", r0_rsp_valid, 0);
        check("rst_p0_rsp_rdata", r0_rsp_rdata, 0);
        check("rst_p1_rsp_err", r1_rsp_err, 0);
        r0_valid = 0; r0_addr = 0;
        init_done = 1;
        reset = 0;

        // write then read back
        step(1, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
        step(1, 0, 32'h10, 0,             0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // round-robin contention
        for (int i = 0; i < 4; i++) step(1, 0, 32'h0, 0, 1, 0, 32'h4, 0, (i % 2 == 0) ? 1 : 2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // error cases, memory left untouched
        step(0, 0, 0, 0, 1, 1, 32'h6, 32'hFFFF_FFFF, 2);
        step(1, 0, 32'h100, 0, 0, 0, 0, 0, 1);
        step(1, 0, 32'h4, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // read-after-write across ports with the pointer on port 1
        step(1, 0, 32'h0, 0, 1, 0, 32'h0, 0, 1);
        step(1, 0, 32'h20, 0, 1, 1, 32'h20, 32'h1234_5678, 2);
        step(1, 0, 32'h20, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // CPU-priority instance: port 1 waits until port 0 drops
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            q0_valid = 1; q0_addr = 32'h0;
            q1_valid = 1; q1_addr = 32'h4;
            @(negedge clk);
            check("prio_p0_ready", q0_ready, 1);
            check("prio_p1_ready", q1_ready, 0);
            if (i > 0) check("prio_p1_rsp_valid", q1_rsp_valid, 0);
        end
        @(posedge clk);
        #1;
        q0_valid = 0;
        @(negedge clk);
        check("prio_p1_granted", q1_ready, 1);
        check("prio_mem_addr", q_mem_addr, 1);
        check("prio_p0_rsp_valid", q0_rsp_valid, 1);
        check("prio_p0_rsp_rdata", q0_rsp_rdata, 32'hA500_0000);
        @(posedge clk);
        #1;
        q1_valid = 0;
        @(negedge clk);
        check("prio_p1_rsp_valid_last", q1_rsp_valid, 1);
        check("prio_p1_rsp_rdata", q1_rsp_rdata, 32'hA500_0001);
        check("prio_p0_rsp_idle", q0_rsp_valid, 0);

        // reset drops an in-flight response and re-centres the pointer on port 0
        step(1, 0, 32'h0, 0, 1, 0, 32'h4, 0, 1);
        step(1, 0, 32'h10, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        r0_valid = 0; r0_addr = 0;
        #1;
        check("pre_rst_rsp_valid", r0_rsp_valid, 1);
        reset = 1;
        #1;
        check("async_rst_rsp_valid", r0_rsp_valid, 0);
        check("async_rst_rsp_rdata", r0_rsp_rdata, 0);
        sbq.delete();
        repeat (2) @(negedge clk);
        reset = 0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 32'h8, 0, 1, 0, 32'hC, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("scoreboard_drained", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 64-word data memory between two requesters: port 0 (CPU load/store unit) and port 1 (debug/loader port).
- Provides:
  - a valid/ready request handshake per port;
  - round-robin arbitration, one memory access per cycle;
  - registered read responses;
  - address/alignment checking.
- Sits between the requesters and the data memory array.
- Drives the memory's write enable, read enable, address and write data. Samples the memory's combinational read data.

Parameters:
- DEPTH, 64, number of 32-bit words in the data memory.
- AW, 6, word-index width, clog2(DEPTH).
- CPU_PRIO, 0, 1 = port 0 always wins when both request; 0 = round-robin.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- p0_valid  in  1  port 0 request valid.
- p0_we  in  1  port 0 write (1) / read (0).
- p0_addr  in  32  port 0 byte address.
- p0_wdata  in  32  port 0 write data.
- p0_ready  out  1  port 0 request accepted this cycle.
- p0_rsp_valid  out  1  port 0 response valid.
- p0_rsp_rdata  out  32  port 0 read data.
- p0_rsp_err  out  1  port 0 access error.
- p1_valid, p1_we, p1_addr, p1_wdata, p1_ready, p1_rsp_valid, p1_rsp_rdata, p1_rsp_err: same as port 0, for port 1.
- mem_we  out  1  memory write enable.
- mem_re  out  1  memory read enable.
- mem_addr  out  AW  memory word index.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, combinational from mem_addr.
- busy  out  1  a grant was issued this cycle.

Behaviour:
- Reset: asserting reset immediately forces every registered output to 0. This covers all *_rsp_valid, *_rsp_rdata and *_rsp_err, and the priority pointer (which resets to favour port 0).
- A transaction in flight when reset is asserted is dropped. No response is produced.
- Combinational outputs (ready, mem_*, busy) are 0 while reset is high.
- Grant decision is combinational, within a cycle, from p0_valid, p1_valid and the pointer:
  - Only one port valid: that port wins.
  - Both valid, CPU_PRIO=1: port 0 wins.
  - Both valid, CPU_PRIO=0: the port named by the pointer wins.
  - The pointer flips to the loser after each contested grant. Uncontested grants leave the pointer unchanged.
- Winner's pX_ready = 1; loser's ready = 0. A loser must hold its valid, we, addr and wdata stable until accepted.
- Address check on the winner:
  - err = addr[1:0] != 0 (misaligned), or addr[31:2] >= DEPTH (out of range).
  - word index = addr[AW+1:2].
- Grant with no error:
  - mem_addr = word index.
  - Write: mem_we = 1, mem_wdata = wdata; the memory writes at the same clock edge.
  - Read: mem_re = 1.
- Grant with error: mem_we = mem_re = 0. The memory is untouched. ready is still asserted and the request is consumed.
- No grant: mem_we = mem_re = 0, mem_addr = 0, mem_wdata = 0.
- Response latency is exactly 1 cycle:
  - On the edge that ends a grant cycle, the winner's rsp_valid is registered to 1 for exactly one cycle.
  - rsp_err = err.
  - rsp_rdata = mem_rdata for a clean read, otherwise 0 (writes and errors).
  - The other port's rsp_valid is 0 in that cycle.
- Throughput: one grant per cycle. Back-to-back requests from the same port are accepted every cycle when uncontested. Responses pipeline with requests (request N+1 is accepted in the same cycle the response to N is presented).
- rsp_rdata holds its last value while rsp_valid = 0. Consumers sample it only when rsp_valid = 1.
- Simultaneous write from one port and read from the other to the same word: the two are serialized by arbitration. The second access sees the result of the first (read-after-write across cycles).
- Read of a word being written in the same cycle: impossible, since only one access is issued per cycle.
- busy = (p0_ready | p1_ready).

Test Plan:
- Reset, then p0 writes 0xDEADBEEF to addr 0x10, then p0 reads 0x10 -> each is accepted in its cycle with p0_ready = 1. Read response arrives 1 cycle later with p0_rsp_rdata = 0xDEADBEEF and err = 0.
- Both ports valid for 4 cycles, CPU_PRIO = 0, reading 0x0 and 0x4 -> grants alternate p0, p1, p0, p1. Each response appears on the correct port 1 cycle after its grant; no cycle grants both.
- Same contention with CPU_PRIO = 1 -> p0 granted all 4 cycles and p1_ready stays 0. p1 is granted in the first cycle p0_valid drops, with p1_addr held stable until then.
- Misaligned p1 write to 0x6, and out-of-range p0 read of 0x100 (word 64) -> mem_we = mem_re = 0 in those cycles and ready = 1. The next cycle shows rsp_err = 1 and rsp_rdata = 0. A subsequent read of word 1 returns its prior contents.
- p1 writes 0x12345678 to 0x20 while p0 reads 0x20 in the same cycle, round-robin favouring p1 -> p1 is granted first. p0's read, one cycle later, returns 0x12345678.
- Assert reset in the cycle after a p0 read grant -> p0_rsp_valid is forced to 0 immediately, no response appears after reset release, and the pointer favours p0 again.
